// File: rtl/generador_control.sv
// generador_control
//
// ID-stage control generator for a five-stage MIPS-style pipeline. It
// decodes the ID instruction into a 10-bit control word and registers that
// word into ID/EX. It also registers the rt field of the instruction that is
// moving into EX. A load-use hazard is detected against the registered EX
// word. On a hazard the block inserts a bubble and counts it, and the
// counter saturates at 0xFFFF.
//
// Ports:
//   clk           rising-edge clock for all state
//   rst_n         synchronous active-low reset
//   Instr[31:0]   ID-stage instruction (opcode [31:26], rs [25:21], rt [20:16])
//   flush         taken branch/jump resolved; the ID instruction is discarded
//   Control[9:0]  registered ID/EX control word:
//                 [9] Saltoincond [8] RegDest [7] FuenteALU [6] MemaReg
//                 [5] EscrReg [4] LeerMem [3] EscrMem [2] SaltoCond [1:0] ALUOp
//   rt_ex[4:0]    registered rt of the instruction now in EX
//   stall         load-use hazard; holds PC and IF/ID this cycle
//   cnt_burbujas  saturating count of inserted bubbles

module generador_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instr,
  input  logic        flush,
  output logic [9:0]  Control,
  output logic [4:0]  rt_ex,
  output logic        stall,
  output logic [15:0] cnt_burbujas
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [9:0] CTRL_RTYPE = 10'h122;
  localparam logic [9:0] CTRL_LW    = 10'h0F0;
  localparam logic [9:0] CTRL_SW    = 10'h088;
  localparam logic [9:0] CTRL_BEQ   = 10'h005;
  localparam logic [9:0] CTRL_J     = 10'h200;
  localparam logic [9:0] CTRL_ADDI  = 10'h0A0;
  localparam logic [9:0] CTRL_NOP   = 10'h000;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [9:0]  decoded;
  logic        hazard;
  logic        unused_low_bits;

  assign opcode = Instr[31:26];
  assign rs     = Instr[25:21];
  assign rt     = Instr[20:16];

  // The immediate and function fields do not affect control generation.
  assign unused_low_bits = ^Instr[15:0];

  // Opcode decode. Any opcode not listed yields an all-zero word, so it
  // behaves as a NOP.
  always_comb begin
    decoded = CTRL_NOP;
    case (opcode)
      OP_RTYPE: decoded = CTRL_RTYPE;
      OP_LW:    decoded = CTRL_LW;
      OP_SW:    decoded = CTRL_SW;
      OP_BEQ:   decoded = CTRL_BEQ;
      OP_J:     decoded = CTRL_J;
      OP_ADDI:  decoded = CTRL_ADDI;
      default:  decoded = CTRL_NOP;
    endcase
  end

  // A load in EX whose destination matches either source of the ID
  // instruction must wait one cycle. Register 0 is never a real dependency.
  // A flush kills the ID instruction, so no stall is raised for it.
  always_comb begin
    hazard = Control[4] && (rt_ex != 5'd0) && ((rt_ex == rs) || (rt_ex == rt));
    stall  = hazard && !flush;
  end

  // ID/EX register and bubble counter. Reset takes priority, then flush,
  // then stall. A bubble clears Control[4], so each load-use stall ends
  // after one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Control      <= CTRL_NOP;
      rt_ex        <= 5'd0;
      cnt_burbujas <= 16'd0;
    end else if (flush) begin
      Control <= CTRL_NOP;
      rt_ex   <= 5'd0;
    end else if (stall) begin
      Control <= CTRL_NOP;
      rt_ex   <= 5'd0;
      if (cnt_burbujas != 16'hFFFF) begin
        cnt_burbujas <= cnt_burbujas + 16'd1;
      end
    end else begin
      Control <= decoded;
      rt_ex   <= rt;
    end
  end

endmodule

// File: tb/tb_generador_control.sv
// tb_generador_control
//
// Directed testbench for generador_control. The bench applies a linear
// sequence of hand-computed vectors: reset state, the decode sweep, a
// load-use stall, a non-hazard on register 0, flush overriding a hazard,
// sw in EX, reset in the middle of a stall, and counter saturation.

module tb_generador_control;

  logic        clk;
  logic        rst_n;
  logic [31:0] Instr;
  logic        flush;
  logic [9:0]  Control;
  logic [4:0]  rt_ex;
  logic        stall;
  logic [15:0] cnt_burbujas;

  int checks;
  int passes;

  generador_control dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Instr        (Instr),
    .flush        (flush),
    .Control      (Control),
    .rt_ex        (rt_ex),
    .stall        (stall),
    .cnt_burbujas (cnt_burbujas)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so that a wedged run still ends with a reported failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Drive the ID-stage inputs. The caller does this just after a rising edge.
  task automatic applyStimulus(input logic [31:0] instrVal, input logic flushVal);
    Instr = instrVal;
    flush = flushVal;
  endtask

  // Advance past the next rising edge. Sampling happens 1 ns later, well away
  // from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One comparison: count it, count the pass, or report the failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) begin
      passes++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [5:0] sweepOps [8];
    logic [9:0] sweepExp [8];

    checks = 0;
    passes = 0;
    rst_n  = 1'b0;
    applyStimulus(32'h0000_0000, 1'b0);

    // Reset state.
    tick();
    tick();
    checkOutput("reset_control", {22'd0, Control}, 32'h000);
    checkOutput("reset_rt_ex", {27'd0, rt_ex}, 32'h0);
    checkOutput("reset_cnt", {16'd0, cnt_burbujas}, 32'h0);
    checkOutput("reset_stall", {31'd0, stall}, 32'h0);

    // Decode sweep. rs and rt are zero, so no hazard can arise between steps.
    rst_n = 1'b1;
    sweepOps[0] = 6'b000000; sweepExp[0] = 10'h122;
    sweepOps[1] = 6'b100011; sweepExp[1] = 10'h0F0;
    sweepOps[2] = 6'b101011; sweepExp[2] = 10'h088;
    sweepOps[3] = 6'b000100; sweepExp[3] = 10'h005;
    sweepOps[4] = 6'b000010; sweepExp[4] = 10'h200;
    sweepOps[5] = 6'b001000; sweepExp[5] = 10'h0A0;
    sweepOps[6] = 6'b111111; sweepExp[6] = 10'h000;
    sweepOps[7] = 6'b000001; sweepExp[7] = 10'h000;
    for (int i = 0; i < 8; i++) begin
      applyStimulus({sweepOps[i], 26'd0}, 1'b0);
      tick();
      checkOutput($sformatf("decode_op%02h", sweepOps[i]), {22'd0, Control},
                  {22'd0, sweepExp[i]});
    end

    // Load-use: lw $9, then add with rs=9.
    applyStimulus(32'h8D09_0000, 1'b0);
    tick();
    applyStimulus(32'h012B_5020, 1'b0);
    #1;
    checkOutput("lu_control_lw", {22'd0, Control}, 32'h0F0);
    checkOutput("lu_rt_ex_lw", {27'd0, rt_ex}, 32'h9);
    checkOutput("lu_stall", {31'd0, stall}, 32'h1);
    tick();
    checkOutput("lu_bubble_control", {22'd0, Control}, 32'h000);
    checkOutput("lu_bubble_rt_ex", {27'd0, rt_ex}, 32'h0);
    checkOutput("lu_cnt", {16'd0, cnt_burbujas}, 32'h1);
    checkOutput("lu_stall_released", {31'd0, stall}, 32'h0);
    tick();
    checkOutput("lu_add_control", {22'd0, Control}, 32'h122);
    checkOutput("lu_add_rt_ex", {27'd0, rt_ex}, 32'hB);

    // lw with rt=0 never creates a hazard.
    applyStimulus(32'h8C00_0000, 1'b0);
    tick();
    applyStimulus(32'h0000_5020, 1'b0);
    #1;
    checkOutput("zero_rt_stall", {31'd0, stall}, 32'h0);
    tick();
    checkOutput("zero_rt_cnt", {16'd0, cnt_burbujas}, 32'h1);
    checkOutput("zero_rt_control", {22'd0, Control}, 32'h122);

    // Flush together with a hazard: no stall and no count.
    applyStimulus(32'h8D09_0000, 1'b0);
    tick();
    applyStimulus(32'h012B_5020, 1'b1);
    #1;
    checkOutput("flush_stall", {31'd0, stall}, 32'h0);
    tick();
    checkOutput("flush_control", {22'd0, Control}, 32'h000);
    checkOutput("flush_rt_ex", {27'd0, rt_ex}, 32'h0);
    checkOutput("flush_cnt", {16'd0, cnt_burbujas}, 32'h1);
    applyStimulus(32'h012B_5020, 1'b0);
    tick();
    checkOutput("flush_after_control", {22'd0, Control}, 32'h122);

    // A store in EX is not a load, so it creates no hazard.
    applyStimulus(32'hAD09_0000, 1'b0);
    tick();
    applyStimulus(32'h012B_5020, 1'b0);
    #1;
    checkOutput("sw_control", {22'd0, Control}, 32'h088);
    checkOutput("sw_stall", {31'd0, stall}, 32'h0);
    tick();

    // Reset during the stall cycle drops the pending bubble.
    applyStimulus(32'h8D09_0000, 1'b0);
    tick();
    applyStimulus(32'h012B_5020, 1'b0);
    #1;
    checkOutput("rst_mid_stall_pre", {31'd0, stall}, 32'h1);
    rst_n = 1'b0;
    tick();
    checkOutput("rst_mid_control", {22'd0, Control}, 32'h000);
    checkOutput("rst_mid_rt_ex", {27'd0, rt_ex}, 32'h0);
    checkOutput("rst_mid_cnt", {16'd0, cnt_burbujas}, 32'h0);
    checkOutput("rst_mid_stall", {31'd0, stall}, 32'h0);
    rst_n = 1'b1;

    // Saturation. The counter is preloaded just below the top so that the
    // run stays short. Three more pairs must stop at 0xFFFF.
    force dut.cnt_burbujas = 16'hFFFD;
    #1;
    release dut.cnt_burbujas;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h8D09_0000, 1'b0);
      tick();
      applyStimulus(32'h012B_5020, 1'b0);
      #1;
      checkOutput($sformatf("sat_stall%0d", i), {31'd0, stall}, 32'h1);
      tick();
      checkOutput($sformatf("sat_cnt%0d", i), {16'd0, cnt_burbujas},
                  (i == 0) ? 32'hFFFE : 32'hFFFF);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/generador_control.md
GENERADOR_CONTROL -- requirements
Module: generador_control

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst_n  input  1  synchronous active-low reset.
REQ-004 SHALL have port: Instr  input  32  ID-stage instruction; opcode = Instr[31:26], rs = Instr[25:21], rt = Instr[20:16].
REQ-005 SHALL have port: flush  input  1  taken branch/jump resolved; ID instruction is discarded.
REQ-006 SHALL have port: Control  output  10  registered ID/EX control word, bit map:
- [9] Saltoincond, [8] RegDest, [7] FuenteALU, [6] MemaReg
- [5] EscrReg, [4] LeerMem, [3] EscrMem, [2] SaltoCond, [1:0] ALUOp
REQ-007 SHALL have port: rt_ex  output  5  registered rt of the instruction now in EX.
REQ-008 SHALL have port: stall  output  1  load-use hazard; holds PC and IF/ID this cycle.
REQ-009 SHALL have port: cnt_burbujas  output  16  count of inserted bubbles, saturating.

Function
REQ-010 SHALL decode opcode combinationally; all others 0:
- 000000 R-type -> 0x122
- 100011 lw -> 0x0F0
- 101011 sw -> 0x088
- 000100 beq -> 0x005
- 000010 j -> 0x200
- 001000 addi -> 0x0A0
- any other opcode -> 0x000
REQ-011 SHALL compute hazard = Control[4] & (rt_ex != 0) & (rt_ex == rs | rt_ex == rt), using the registered Control and rt_ex.
REQ-012 SHALL drive stall = hazard & ~flush, combinationally, in the same cycle.
REQ-013 On each rising clk edge with rst_n=1, SHALL update registers in priority order:
- flush=1 -> Control<=0x000, rt_ex<=0
- else stall=1 -> Control<=0x000 (bubble), rt_ex<=0, cnt_burbujas += 1
- else -> Control<=decoded word, rt_ex<=Instr[20:16]
REQ-014 SHALL give a latency of exactly 1 cycle from Instr to Control when no flush or stall occurs.
REQ-015 SHALL make a stall last exactly one cycle per load-use pair, because the bubble clears Control[4].
REQ-016 SHALL hold cnt_burbujas at 0xFFFF once reached; it SHALL NOT wrap.
REQ-017 SHALL NOT count a bubble when flush and hazard occur together (stall=0).
REQ-018 SHALL NOT flag a hazard when rt_ex=0, regardless of rs/rt.
REQ-019 SHALL NOT flag a hazard from a sw or R-type in EX (Control[4]=0).

Reset
REQ-020 With rst_n=0 at a rising edge, SHALL set Control=0x000, rt_ex=0, cnt_burbujas=0; consequently stall=0 in the next cycle.
REQ-021 SHALL give reset priority over flush and stall, including a reset asserted mid-stall; the pending bubble SHALL be dropped and not counted.
REQ-022 SHALL behave as if the first instruction after rst_n rises has no EX predecessor.

Verification
REQ-023 Decode sweep: apply each opcode in REQ-010 plus 0x3F, one per cycle -> Control matches the table one cycle later; 0x3F gives 0x000.
REQ-024 Load-use: Instr=0x8D090000 (lw rt=9), then 0x012B5020 (add, rs=9):
- Control=0x0F0 and stall=1 in the second cycle
- then Control=0x000, cnt_burbujas=1, stall=0
- add is re-presented -> Control=0x122
REQ-025 Non-hazard: lw rt=0 (0x8C000000) followed by add rs=0 -> stall stays 0 and cnt_burbujas stays 0.
REQ-026 Flush vs hazard: lw rt=9, then add rs=9 with flush=1 in the same cycle -> stall=0, next Control=0x000, cnt_burbujas unchanged.
REQ-027 Saturation: preload via 65535 load-use pairs, then one more pair -> cnt_burbujas stays 0xFFFF.
REQ-028 Reset mid-stall: drive rst_n=0 during the cycle with stall=1 -> Control=0x000, rt_ex=0, cnt_burbujas=0 after the edge.
